ysyx_22040895_isram: RTL and testbench



---
 rtl/ysyx_22040895_isram.sv | 158 +++++++++++++++
 tb/tb_ysyx_22040895_isram.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22040895_isram.sv
// Instruction-memory responder: valid/ready fetch request in, instruction word out after a programmable wait.
// Define ISRAM_RAND_DELAY_EN to add an LFSR-driven 0..3 cycle jitter on top of LATENCY.
module ysyx_22040895_isram #(
  parameter int unsigned        ADDR_W    = 64,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 4096,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 64'h8000_0000,
  parameter int unsigned        LATENCY   = 1,
  localparam int unsigned       IDX_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] araddr_i,
  input  logic              arvalid_i,
  output logic              arready_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rvalid_o,
  input  logic              rready_i,
  input  logic              prog_we_i,
  input  logic [IDX_W-1:0]  prog_idx_i,
  input  logic [DATA_W-1:0] prog_data_i
);

  // Wide enough for LATENCY (<=15) plus the optional 0..3 jitter.
  localparam int unsigned CNT_W = 5;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              arready_d;
  logic              rvalid_d;
  logic [DATA_W-1:0] rdata_d;
  logic [1:0]        rresp_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  rd_idx;
  logic              addr_err;
  logic [CNT_W-1:0]  wait_load;

  assign accept = arvalid_i & arready_o;

  // The below-base check catches underflow; the wrapped offset is never trusted on its own.
  assign offset   = addr_q - BASE_ADDR;
  assign rd_idx   = offset[IDX_W+1:2];
  assign addr_err = (addr_q[1:0] != 2'b00)
                 || (addr_q < BASE_ADDR)
                 || ((offset >> 2) >= ADDR_W'(DEPTH));

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, stepped once per accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= 8'hA5;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign wait_load = CNT_W'(LATENCY) + CNT_W'(lfsr_q[1:0]);
`else
  assign wait_load = CNT_W'(LATENCY);
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    arready_d = arready_o;
    rvalid_d  = rvalid_o;
    rdata_d   = rdata_o;
    rresp_d   = rresp_o;

    unique case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (accept) begin
          addr_d    = araddr_i;
          cnt_d     = wait_load;
          arready_d = 1'b0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          if (addr_err) begin
            rdata_d = '0;
            rresp_d = RESP_ERR;
          end else begin
            rdata_d = mem[rd_idx];
            rresp_d = RESP_OKAY;
          end
        end
      end

      RESP: begin
        if (rready_i) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      arready_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      rresp_o   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      arready_o <= arready_d;
      rvalid_o  <= rvalid_d;
      rdata_o   <= rdata_d;
      rresp_o   <= rresp_d;
    end
  end

  // NOTE: the array has no reset so it maps onto RAM and keeps the loaded program across resets.
  always_ff @(posedge clk) begin
    if (rst && prog_we_i) begin
      mem[prog_idx_i] <= prog_data_i;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_isram.sv
// Scoreboard bench: two responders (LATENCY=1 and LATENCY=0) share stimulus; a negedge monitor checks each response.
// Build with ISRAM_RAND_DELAY_EN defined to check the jittered latencies against a reference LFSR.
module tb_ysyx_22040895_isram;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int unsigned lat;
    int unsigned acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b1;
  logic        prog_we = 1'b0;
  logic [11:0] prog_idx = '0;
  logic [31:0] prog_data = '0;

  logic [1:0]  arready;
  logic [1:0]  rvalid;
  logic [31:0] rdata [2];
  logic [1:0]  rresp [2];
  logic [1:0]  rv_prev = 2'b00;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] img [16];

`ifdef ISRAM_RAND_DELAY_EN
  logic [7:0]  lfsr_m = 8'hA5;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_22040895_isram #(.LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[0]),
    .rdata_o(rdata[0]), .rresp_o(rresp[0]), .rvalid_o(rvalid[0]), .rready_i(rready),
    .prog_we_i(prog_we), .prog_idx_i(prog_idx), .prog_data_i(prog_data)
  );

  ysyx_22040895_isram #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready[1]),
    .rdata_o(rdata[1]), .rresp_o(rresp[1]), .rvalid_o(rvalid[1]), .rready_i(rready),
    .prog_we_i(prog_we), .prog_idx_i(prog_idx), .prog_data_i(prog_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_rise(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      check($sformatf("dut%0d_spurious_rvalid", d), 64'(rvalid[d]), 64'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("dut%0d_rdata", d), 64'(rdata[d]), 64'(e.data));
    check($sformatf("dut%0d_rresp", d), 64'(rresp[d]), 64'(e.resp));
    check($sformatf("dut%0d_latency", d), 64'(cyc - e.acc), 64'(e.lat));
  endtask

  // Monitor: a rising rvalid is one response; compare it against the oldest expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rvalid[d] && !rv_prev[d]) mon_rise(d);
    end
    rv_prev <= rvalid;
  end

  task automatic prog(input logic [11:0] idx, input logic [31:0] data);
    prog_we   = 1'b1;
    prog_idx  = idx;
    prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
    if (rst && idx < 12'd16) img[idx[3:0]] = data;
  endtask

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic issue(input logic [63:0] addr, input logic [31:0] data, input logic [1:0] resp,
                       output int unsigned lat1);
    exp_t        e;
    int          n = 0;
    int unsigned extra = 0;
    while (arready != 2'b11 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (arready != 2'b11) check("issue_ready_timeout", 64'(arready), 64'd3);
`ifdef ISRAM_RAND_DELAY_EN
    extra  = int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
    araddr  = addr;
    arvalid = 1'b1;
    e.data = data;
    e.resp = resp;
    e.acc  = cyc + 1;
    e.lat  = 1 + extra;
    q0.push_back(e);
    e.lat  = 2 + extra;
    q1.push_back(e);
    lat1 = 2 + extra;
    @(negedge clk);
    arvalid = 1'b0;
    check("accept_dut0", 64'(arready[0]), 64'd0);
    check("accept_dut1", 64'(arready[1]), 64'd0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(arready == 2'b11 && rvalid == 2'b00) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(arready == 2'b11 && rvalid == 2'b00)) check("idle_timeout", 64'({arready, rvalid}), 64'hC);
  endtask

  task automatic wait_rvalid1();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid[1] && n < 40);
    if (!rvalid[1]) check("rvalid_timeout", 64'(rvalid[1]), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned lat;

    #1 rst = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_arready%0d", d), 64'(arready[d]), 64'd0);
      check($sformatf("reset_rvalid%0d", d), 64'(rvalid[d]), 64'd0);
      check($sformatf("reset_rdata%0d", d), 64'(rdata[d]), 64'd0);
      check($sformatf("reset_rresp%0d", d), 64'(rresp[d]), 64'd0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("release_arready_pre_edge", 64'(arready), 64'd0);
    @(negedge clk);
    check("release_arready_first_edge", 64'(arready), 64'd3);

    prog(12'd0, 32'h0000_0297);
    prog(12'd1, 32'h0010_0073);
    for (int k = 2; k < 16; k++) prog(12'(k), 32'hA000_0000 | 32'(k));
    prog(12'd4095, 32'h0BAD_F00D);

    // Basic fetch, then arready must be back one edge after the response.
    issue(64'h8000_0000, 32'h0000_0297, 2'b00, lat);
    wait_rvalid1();
    @(negedge clk);
    check("arready_after_resp", 64'(arready[1]), 64'd1);
    check("rvalid_after_resp", 64'(rvalid[1]), 64'd0);
    wait_idle();

    // Decode boundaries.
    issue(64'h8000_0002, 32'h0, 2'b10, lat);            wait_idle();
    issue(64'h8000_4000, 32'h0, 2'b10, lat);            wait_idle();
    issue(64'h7FFF_FFFC, 32'h0, 2'b10, lat);            wait_idle();
    issue(64'h0000_0000, 32'h0, 2'b10, lat);            wait_idle();
    issue(64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 2'b10, lat);  wait_idle();
    issue(64'h8000_3FFC, 32'h0BAD_F00D, 2'b00, lat);    wait_idle();
    issue(64'h8000_0004, 32'h0010_0073, 2'b00, lat);    wait_idle();

    // Back-pressure: response held, second request ignored.
    rready = 1'b0;
    issue(64'h8000_000C, 32'hA000_0003, 2'b00, lat);
    wait_rvalid1();
    araddr  = 64'h8000_0008;
    arvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rvalid1", 64'(rvalid[1]), 64'd1);
      check("stall_rdata1", 64'(rdata[1]), 64'hA000_0003);
      check("stall_rresp1", 64'(rresp[1]), 64'd0);
      check("stall_rvalid0", 64'(rvalid[0]), 64'd1);
      check("stall_rdata0", 64'(rdata[0]), 64'hA000_0003);
      check("stall_arready", 64'(arready), 64'd0);
    end
    arvalid = 1'b0;
    rready  = 1'b1;
    wait_idle();
    repeat (4) @(negedge clk);

    // Program write landing on the RESP-entry edge returns the old word.
    issue(64'h8000_0008, img[2], 2'b00, lat);
    for (int i = 1; i < int'(lat); i++) @(negedge clk);
    prog(12'd2, 32'hCAFE_0002);
    wait_idle();
    issue(64'h8000_0008, 32'hCAFE_0002, 2'b00, lat);
    wait_idle();

    // Reset while waiting: response dropped, array kept, program port ignored.
    issue(64'h8000_0000, 32'h0000_0297, 2'b00, lat);
    rst = 1'b0;
    #1;
    check("midreset_rvalid", 64'(rvalid), 64'd0);
    check("midreset_arready", 64'(arready), 64'd0);
    q0.delete();
    q1.delete();
`ifdef ISRAM_RAND_DELAY_EN
    lfsr_m = 8'hA5;
`endif
    @(negedge clk);
    prog(12'd5, 32'hDEAD_BEEF);
    rst = 1'b1;
    check("midreset_release_pre_edge", 64'(arready), 64'd0);
    @(negedge clk);
    check("midreset_release_edge", 64'(arready), 64'd3);
    issue(64'h8000_0000, 32'h0000_0297, 2'b00, lat);  wait_idle();
    issue(64'h8000_0014, 32'hA000_0005, 2'b00, lat);  wait_idle();

    // Sixteen sequential fetches.
    for (int k = 0; k < 16; k++) begin
      issue(64'h8000_0000 + 64'(4 * k), img[k], 2'b00, lat);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
